// File: rtl/fp_pkg.sv
// Shared fixed-point datapath definitions: default word format, accumulator FSM
// states and sign-magnitude / two's complement conversion helpers.
package fp_pkg;

    localparam int N_DEF  = 16;
    localparam int Q_DEF  = 7;
    localparam int G_DEF  = 4;
    localparam int CW_DEF = 8;
    localparam int AW_DEF = N_DEF + G_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [AW_DEF-1:0] sm_to_tc(input logic [N_DEF-1:0] sm);
        logic [AW_DEF-1:0] mag;
        mag = {{(G_DEF+1){1'b0}}, sm[N_DEF-2:0]};
        return sm[N_DEF-1] ? (~mag + 1'b1) : mag;
    endfunction

    // Returns {ovr, sign-magnitude word}; out-of-range values clamp to +/-max.
    function automatic logic [N_DEF:0] tc_to_sm_sat(input logic [AW_DEF-1:0] tc);
        logic signed [AW_DEF-1:0] tc_s;
        logic signed [AW_DEF-1:0] pos_lim;
        logic [N_DEF-2:0] neg_mag;
        tc_s    = $signed(tc);
        pos_lim = $signed({{(G_DEF+1){1'b0}}, {(N_DEF-1){1'b1}}});
        neg_mag = ~tc[N_DEF-2:0] + 1'b1;
        if (tc_s > pos_lim)
            return {1'b1, 1'b0, {(N_DEF-1){1'b1}}};
        else if (tc_s < -pos_lim)
            return {1'b1, 1'b1, {(N_DEF-1){1'b1}}};
        else if (tc[AW_DEF-1])
            return {1'b0, 1'b1, neg_mag};
        else
            return {1'b0, 1'b0, tc[N_DEF-2:0]};
    endfunction

endpackage

// File: rtl/fp_sat_conv.sv
// Combinational (N+G)-bit two's complement to N-bit sign-magnitude with
// saturation; ovr flags a clamped value.
module fp_sat_conv #(
    parameter int N = 16,
    parameter int G = 4
) (
    input  logic [N+G-1:0] acc,
    output logic [N-1:0]   sm,
    output logic           ovr
);

    localparam int AW = N + G;
    localparam logic signed [AW-1:0] POS_LIM = {{(G+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] NEG_LIM = -POS_LIM;

    logic signed [AW-1:0] acc_s;
    logic [N-2:0]         neg_mag;

    assign acc_s   = $signed(acc);
    // Low bits of the negation only; the range checks guarantee the rest are zero.
    assign neg_mag = ~acc[N-2:0] + 1'b1;

    always_comb begin
        sm  = '0;
        ovr = 1'b0;
        if (acc_s > POS_LIM) begin
            sm  = {1'b0, {(N-1){1'b1}}};
            ovr = 1'b1;
        end else if (acc_s < NEG_LIM) begin
            sm  = {1'b1, {(N-1){1'b1}}};
            ovr = 1'b1;
        end else if (acc[AW-1]) begin
            sm = {1'b1, neg_mag};
        end else begin
            sm = {1'b0, acc[N-2:0]};
        end
    end

endmodule

// File: rtl/fp_mac_accum.sv
// Burst accumulator for sign-magnitude products: sums i_len terms with a
// saturating guard-extended accumulator and reports sticky overflow per burst.
//
// state    | meaning
// ST_IDLE  | ready for i_start; accumulator cleared and counter loaded on start
// ST_ACCUM | accepting terms on i_valid; counter holds terms still to come
// ST_DONE  | one-cycle o_valid strobe with the registered result
module fp_mac_accum
    import fp_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int Q  = Q_DEF,
    parameter int G  = G_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [CW-1:0] i_len,
    input  logic          i_valid,
    input  logic [N-1:0]  i_term,
    input  logic          i_term_ovr,
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_valid,
    output logic [N-1:0]  o_result,
    output logic          o_ovr
);

    localparam int AW = N + G;
    localparam logic signed [AW:0] SUM_MAX = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW:0] SUM_MIN = -SUM_MAX;

    // Q only fixes the binary point; addition is scale-free, so it is just range-checked.
    if (Q >= N) begin : g_bad_q
        $error("fp_mac_accum: Q must be smaller than N");
    end

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, term_mag, term_tc, sum_sat, conv_in;
    logic signed [AW:0] sum_wide;
    logic [CW-1:0]    cnt_q;
    logic             ovr_q, accept, last_term, add_sat, conv_ovr, fin_ovr;
    logic [N-1:0]     conv_sm, result_q;
    logic             result_ovr_q;

    assign term_mag  = {{(G+1){1'b0}}, i_term[N-2:0]};
    assign term_tc   = i_term[N-1] ? (~term_mag + 1'b1) : term_mag;
    assign accept    = (state_q == ST_ACCUM) && i_valid;
    assign last_term = accept && (cnt_q == CW'(1));
    assign sum_wide  = $signed({acc_q[AW-1], acc_q}) + $signed({term_tc[AW-1], term_tc});

    always_comb begin
        sum_sat = sum_wide[AW-1:0];
        add_sat = 1'b0;
        if (sum_wide > SUM_MAX) begin
            sum_sat = SUM_MAX[AW-1:0];
            add_sat = 1'b1;
        end else if (sum_wide < SUM_MIN) begin
            sum_sat = SUM_MIN[AW-1:0];
            add_sat = 1'b1;
        end
    end

    // A zero-length burst enters DONE straight from IDLE with an empty sum.
    assign conv_in = (state_q == ST_ACCUM) ? sum_sat : '0;
    assign fin_ovr = (state_q == ST_ACCUM) ? (ovr_q | i_term_ovr | add_sat | conv_ovr) : 1'b0;

    fp_sat_conv #(.N(N), .G(G)) u_sat_conv (
        .acc (conv_in),
        .sm  (conv_sm),
        .ovr (conv_ovr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = (i_len == '0) ? ST_DONE : ST_ACCUM;
            ST_ACCUM: if (last_term) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            ST_IDLE:  o_ready = 1'b1;
            ST_ACCUM: o_busy  = 1'b1;
            ST_DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
            end
            default:  o_ready = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            ovr_q        <= 1'b0;
            result_q     <= '0;
            result_ovr_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && i_start) begin
                acc_q <= '0;
                ovr_q <= 1'b0;
                cnt_q <= i_len;
            end else if (accept) begin
                acc_q <= sum_sat;
                ovr_q <= ovr_q | i_term_ovr | add_sat;
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_d == ST_DONE) begin
                result_q     <= conv_sm;
                result_ovr_q <= fin_ovr;
            end
        end
    end

    assign o_result = result_q;
    assign o_ovr    = result_ovr_q;

endmodule
